// File: rtl/hub75_rx_capture.sv
// HUB75 receiver: oversamples the panel bus, rebuilds each latched line and
// writes it into a {row,col}-addressed RGB565 frame memory.
//
// Ports
//   clk, rst                  system clock, async active-high reset
//   hub_clk, hub_stb, hub_oe  HUB75 shift clock, latch strobe, blank (1 = off)
//   hub_sel[ROW_BITS-1:0]     row select {D,C,B,A}
//   hub_r, hub_g, hub_b       serial colour bits (upper half)
//   mem_wen/addr/wdata        frame memory write port
//   line_done, frame_done     pulses with the last write of a line / of row 15
//   err_overrun, err_unblank  protocol error pulses
module hub75_rx_capture #(
  parameter int COLS        = 64,
  parameter int ROW_BITS    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         hub_clk,
  input  logic                         hub_stb,
  input  logic                         hub_oe,
  input  logic [ROW_BITS-1:0]          hub_sel,
  input  logic                         hub_r,
  input  logic                         hub_g,
  input  logic                         hub_b,
  output logic                         mem_wen,
  output logic [ROW_BITS+$clog2(COLS)-1:0] mem_addr,
  output logic [15:0]                  mem_wdata,
  output logic                         line_done,
  output logic                         frame_done,
  output logic                         err_overrun,
  output logic                         err_unblank
);

  localparam int CB = $clog2(COLS);
  localparam int IW = ROW_BITS + 6;

  typedef enum logic {S_IDLE, S_WRITE} state_t;

  state_t r_state, w_state_nxt;

  logic [SYNC_STAGES-1:0][IW-1:0] r_sync;
  logic [1:0]                     r_hist;
  logic [COLS-1:0][2:0]           r_shift_buf;
  logic [COLS-1:0][2:0]           r_wr_buf;
  logic [COLS-1:0][2:0]           w_line;
  logic [CB:0]                    r_col_cnt;
  logic [CB-1:0]                  r_wcol;
  logic [CB-1:0]                  w_wcol_nxt;
  logic [ROW_BITS-1:0]            r_row;

  logic [IW-1:0]       w_pins;
  logic [IW-1:0]       w_s;
  logic                w_clk_s;
  logic                w_stb_s;
  logic                w_oe_s;
  logic [ROW_BITS-1:0] w_sel_s;
  logic [2:0]          w_rgb_s;
  logic                w_shift_rise;
  logic                w_latch_rise;
  logic                w_full;
  logic                w_shift_ok;
  logic                w_accept;
  logic                w_busy;

  function automatic logic [15:0] f_rgb565(input logic [2:0] p);
    return {{5{p[2]}}, {6{p[1]}}, {5{p[0]}}};
  endfunction

  assign w_pins = {hub_clk, hub_stb, hub_oe, hub_sel,
                   hub_r, hub_g, hub_b};
  assign w_s     = r_sync[SYNC_STAGES-1];
  assign w_clk_s = w_s[IW-1];
  assign w_stb_s = w_s[IW-2];
  assign w_oe_s  = w_s[IW-3];
  assign w_sel_s = w_s[ROW_BITS+2:3];
  assign w_rgb_s = w_s[2:0];

  assign w_shift_rise = w_clk_s & ~r_hist[1];
  assign w_latch_rise = w_stb_s & ~r_hist[0];

  // COLS is a power of 2, so the counter MSB marks a full buffer
  assign w_full     = r_col_cnt[CB];
  assign w_shift_ok = w_shift_rise & ~w_full;
  assign w_busy     = (r_state == S_WRITE);
  assign w_accept   = w_latch_rise & ~w_busy;
  assign w_wcol_nxt = r_wcol + 1'b1;

  // Line as it stands after this cycle's shift, so a shift edge
  // coinciding with the latch lands in the copied line
  always_comb begin
    w_line = r_shift_buf;
    if (w_shift_ok) begin
      w_line[r_col_cnt[CB-1:0]] = w_rgb_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_hist <= '0;
    end else begin
      r_sync[0] <= w_pins;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_hist <= {w_clk_s, w_stb_s};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_WRITE;
      S_WRITE: if (r_wcol == '1) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift_buf <= '0;
      r_wr_buf    <= '0;
      r_col_cnt   <= '0;
      r_row       <= '0;
    end else if (w_accept) begin
      r_shift_buf <= '0;
      r_wr_buf    <= w_line;
      r_col_cnt   <= '0;
      r_row       <= w_sel_s;
    end else if (w_shift_ok) begin
      r_shift_buf <= w_line;
      r_col_cnt   <= r_col_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wcol      <= '0;
      mem_wen     <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      line_done   <= 1'b0;
      frame_done  <= 1'b0;
      err_overrun <= 1'b0;
      err_unblank <= 1'b0;
    end else begin
      mem_wen     <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      line_done   <= 1'b0;
      frame_done  <= 1'b0;
      err_overrun <= (w_shift_rise & w_full) |
                     (w_latch_rise & w_busy);
      err_unblank <= w_latch_rise & ~w_oe_s;
      if (w_accept) begin
        // column 0 comes straight from the line being latched
        r_wcol    <= '0;
        mem_wen   <= 1'b1;
        mem_addr  <= {w_sel_s, {CB{1'b0}}};
        mem_wdata <= f_rgb565(w_line[0]);
      end else if (w_busy && r_wcol != '1) begin
        r_wcol    <= w_wcol_nxt;
        mem_wen   <= 1'b1;
        mem_addr  <= {r_row, w_wcol_nxt};
        mem_wdata <= f_rgb565(r_wr_buf[w_wcol_nxt]);
        if (w_wcol_nxt == '1) begin
          line_done  <= 1'b1;
          frame_done <= (r_row == '1);
        end
      end
    end
  end

endmodule

// File: tb/tb_hub75_rx_capture.sv
// Directed bench for hub75_rx_capture: line capture, partial lines,
// full frame, overrun/unblank errors and mid-write reset.
module tb_hub75_rx_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hub_clk = 1'b0;
  logic        hub_stb = 1'b0;
  logic        hub_oe = 1'b1;
  logic [3:0]  hub_sel = '0;
  logic        hub_r = 1'b0;
  logic        hub_g = 1'b0;
  logic        hub_b = 1'b0;
  logic        mem_wen;
  logic [9:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        line_done;
  logic        frame_done;
  logic        err_overrun;
  logic        err_unblank;

  int total = 0;
  int bad = 0;

  logic [9:0]  wa_q[$];
  logic [15:0] wd_q[$];
  logic [15:0] mem_m [1024];
  int n_line = 0;
  int n_frame = 0;
  int n_ovr = 0;
  int n_unb = 0;

  hub75_rx_capture dut (
    .clk(clk), .rst(rst),
    .hub_clk(hub_clk), .hub_stb(hub_stb), .hub_oe(hub_oe),
    .hub_sel(hub_sel),
    .hub_r(hub_r), .hub_g(hub_g), .hub_b(hub_b),
    .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .line_done(line_done), .frame_done(frame_done),
    .err_overrun(err_overrun), .err_unblank(err_unblank)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_wen) begin
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_wdata);
      mem_m[mem_addr] = mem_wdata;
    end
    if (line_done)   n_line++;
    if (frame_done)  n_frame++;
    if (err_overrun) n_ovr++;
    if (err_unblank) n_unb++;
  end

  function automatic logic [15:0] c565(input logic [2:0] p);
    logic [15:0] v;
    v = 16'h0000;
    if (p[2]) v = v | 16'hF800;
    if (p[1]) v = v | 16'h07E0;
    if (p[0]) v = v | 16'h001F;
    return v;
  endfunction

  function automatic logic [2:0] img(input int row, input int col);
    if (col == 0 && row == 0) return 3'b001;
    if (col == 0 && row == 1) return 3'b100;
    return 3'((row * 7 + col * 3) % 8);
  endfunction

  task automatic px(input logic [2:0] c);
    @(negedge clk);
    {hub_r, hub_g, hub_b} = c;
    hub_clk = 1'b1;
    repeat (3) @(negedge clk);
    hub_clk = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic latch(input logic [3:0] sel, input logic oe);
    @(negedge clk);
    hub_sel = sel;
    hub_oe  = oe;
    hub_stb = 1'b1;
    repeat (3) @(negedge clk);
    hub_stb = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_writes(input int target);
    for (int i = 0; i < 3000; i++) begin
      if (wa_q.size() >= target) break;
      @(negedge clk);
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({mem_wen, mem_addr, mem_wdata} !== 27'd0) begin
      bad++;
      $display("FAIL reset_mem got=%h want=0",
               {mem_wen, mem_addr, mem_wdata});
    end
    total++;
    if ({line_done, frame_done, err_overrun, err_unblank} !== 4'd0) begin
      bad++;
      $display("FAIL reset_pulses got=%b want=0000",
               {line_done, frame_done, err_overrun, err_unblank});
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_full_line;
    int b;
    int bl;
    int bf;
    logic [15:0] exp_d;
    b  = wa_q.size();
    bl = n_line;
    bf = n_frame;
    for (int k = 0; k < 64; k++) begin
      px((k % 3 == 0) ? 3'b100 : (k % 3 == 1) ? 3'b010 : 3'b001);
    end
    latch(4'd5, 1'b1);
    wait_writes(b + 64);
    total++;
    if (wa_q.size() != b + 64) begin
      bad++;
      $display("FAIL full_count got=%0d want=64", wa_q.size() - b);
    end
    for (int k = 0; k < 64 && b + k < wa_q.size(); k++) begin
      exp_d = (k % 3 == 0) ? 16'hF800 :
              (k % 3 == 1) ? 16'h07E0 : 16'h001F;
      total++;
      if (wa_q[b+k] !== 10'(10'h140 + k) || wd_q[b+k] !== exp_d) begin
        bad++;
        $display("FAIL full_word%0d got=%h/%h want=%h/%h", k,
                 wa_q[b+k], wd_q[b+k], 10'(10'h140 + k), exp_d);
      end
    end
    total++;
    if (n_line - bl != 1 || n_frame - bf != 0) begin
      bad++;
      $display("FAIL full_done got=%0d/%0d want=1/0",
               n_line - bl, n_frame - bf);
    end
  endtask

  task automatic test_partial;
    int b;
    logic [15:0] exp_d;
    b = wa_q.size();
    for (int k = 0; k < 10; k++) px(3'((k % 7) + 1));
    latch(4'd2, 1'b1);
    wait_writes(b + 64);
    total++;
    if (wa_q.size() != b + 64) begin
      bad++;
      $display("FAIL part_count got=%0d want=64", wa_q.size() - b);
    end
    for (int k = 0; k < 64 && b + k < wa_q.size(); k++) begin
      exp_d = (k < 10) ? c565(3'((k % 7) + 1)) : 16'h0000;
      total++;
      if (wa_q[b+k] !== 10'(10'h080 + k) || wd_q[b+k] !== exp_d) begin
        bad++;
        $display("FAIL part_word%0d got=%h/%h want=%h/%h", k,
                 wa_q[b+k], wd_q[b+k], 10'(10'h080 + k), exp_d);
      end
    end
  endtask

  task automatic test_frame;
    int bf;
    int b;
    bf = n_frame;
    b  = wa_q.size();
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 64; c++) px(img(r, c));
      latch(4'(r), 1'b1);
    end
    wait_writes(b + 1024);
    total++;
    if (n_frame - bf != 1) begin
      bad++;
      $display("FAIL frame_done got=%0d want=1", n_frame - bf);
    end
    total++;
    if (mem_m[0] !== 16'h001F || mem_m[64] !== 16'hF800) begin
      bad++;
      $display("FAIL frame_w0_w64 got=%h/%h want=001f/f800",
               mem_m[0], mem_m[64]);
    end
    for (int a = 0; a < 1024; a++) begin
      total++;
      if (mem_m[a] !== c565(img(a / 64, a % 64))) begin
        bad++;
        $display("FAIL frame_word%0d got=%h want=%h", a,
                 mem_m[a], c565(img(a / 64, a % 64)));
      end
    end
  endtask

  task automatic test_errors;
    int b;
    int bo;
    int bu;
    int bl;
    bo = n_ovr;
    for (int k = 0; k < 64; k++) px(3'b011);
    total++;
    if (n_ovr != bo) begin
      bad++;
      $display("FAIL ovr_early got=%0d want=0", n_ovr - bo);
    end
    px(3'b100);
    repeat (2) @(negedge clk);
    total++;
    if (n_ovr - bo != 1) begin
      bad++;
      $display("FAIL ovr_65th got=%0d want=1", n_ovr - bo);
    end
    b  = wa_q.size();
    bl = n_line;
    latch(4'd12, 1'b1);
    repeat (14) @(negedge clk);
    latch(4'd12, 1'b1);
    wait_writes(b + 64);
    repeat (70) @(negedge clk);
    total++;
    if (n_ovr - bo != 2) begin
      bad++;
      $display("FAIL ovr_busy got=%0d want=2", n_ovr - bo);
    end
    total++;
    if (wa_q.size() - b != 64 || n_line - bl != 1) begin
      bad++;
      $display("FAIL ovr_writes got=%0d/%0d want=64/1",
               wa_q.size() - b, n_line - bl);
    end
    total++;
    if (b + 63 < wa_q.size() && wd_q[b+63] !== 16'h07FF) begin
      bad++;
      $display("FAIL ovr_drop got=%h want=07ff", wd_q[b+63]);
    end
    bu = n_unb;
    b  = wa_q.size();
    latch(4'd1, 1'b0);
    wait_writes(b + 64);
    total++;
    if (n_unb - bu != 1) begin
      bad++;
      $display("FAIL unblank got=%0d want=1", n_unb - bu);
    end
    hub_oe = 1'b1;
  endtask

  task automatic test_reset_mid;
    int b;
    int bl;
    b  = wa_q.size();
    bl = n_line;
    for (int k = 0; k < 40; k++) px(3'b111);
    latch(4'd9, 1'b1);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      #1;
      if (wa_q.size() >= b + 30) break;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (mem_wen !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_wen got=%b want=0", mem_wen);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    total++;
    if (wa_q.size() - b != 30 || n_line != bl) begin
      bad++;
      $display("FAIL rst_mid_stop got=%0d/%0d want=30/0",
               wa_q.size() - b, n_line - bl);
    end
    // 5 shifts, then shift and latch on the same cycle
    b = wa_q.size();
    for (int k = 0; k < 5; k++) px(3'b001);
    @(negedge clk);
    {hub_r, hub_g, hub_b} = 3'b110;
    hub_sel = 4'd7;
    hub_oe  = 1'b1;
    hub_clk = 1'b1;
    hub_stb = 1'b1;
    repeat (3) @(negedge clk);
    hub_clk = 1'b0;
    hub_stb = 1'b0;
    repeat (2) @(negedge clk);
    wait_writes(b + 64);
    total++;
    if (wa_q.size() - b != 64) begin
      bad++;
      $display("FAIL same_count got=%0d want=64", wa_q.size() - b);
    end
    total++;
    if (b + 6 < wa_q.size() &&
        (wa_q[b] !== 10'h1C0 || wd_q[b+4] !== 16'h001F ||
         wd_q[b+5] !== 16'hFFE0 || wd_q[b+6] !== 16'h0000)) begin
      bad++;
      $display("FAIL same_line got=%h %h %h %h want=1c0 001f ffe0 0000",
               wa_q[b], wd_q[b+4], wd_q[b+5], wd_q[b+6]);
    end
    b = wa_q.size();
    px(3'b010);
    latch(4'd3, 1'b1);
    wait_writes(b + 64);
    total++;
    if (b + 1 < wa_q.size() &&
        (wa_q[b] !== 10'h0C0 || wd_q[b] !== 16'h07E0 ||
         wd_q[b+1] !== 16'h0000)) begin
      bad++;
      $display("FAIL same_cnt0 got=%h %h %h want=0c0 07e0 0000",
               wa_q[b], wd_q[b], wd_q[b+1]);
    end
  endtask

  initial begin
    test_reset;
    test_full_line;
    test_partial;
    test_errors;
    test_frame;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
